// File: rtl/apb_req_bridge_pkg.sv
// Shared types for the request-to-APB bridge: default APB payload structs,
// the address-map rule layout and the bridge FSM state encoding.
package apb_req_bridge_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [2:0]           prot_t;

  typedef struct packed {
    addr_t paddr;
    prot_t pprot;
    logic  psel;
    logic  penable;
    logic  pwrite;
    data_t pwdata;
    strb_t pstrb;
  } apb_req_t;

  typedef struct packed {
    logic  pready;
    data_t prdata;
    logic  pslverr;
  } apb_resp_t;

  typedef struct packed {
    logic [31:0] idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } apb_rule_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/apb_req_bridge_addr_decode.sv
// Address decoder: first matching rule (start <= addr < end) wins; a match
// whose index is out of range for the port count is reported as a miss.
module apb_req_bridge_addr_decode #(
  parameter int unsigned NoIndices = 32'd2,
  parameter int unsigned NoRules   = 32'd2,
  parameter type         addr_t    = logic [31:0],
  parameter type         rule_t    = apb_req_bridge_pkg::apb_rule_t,
  localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
  input  addr_t               addr_i,
  input  rule_t               addr_map_i [NoRules],
  output logic [IdxWidth-1:0] idx_o,
  output logic                dec_valid_o
);

  logic [NoRules-1:0] match;

  for (genvar gi = 0; gi < NoRules; gi++) begin : g_match
    assign match[gi] = (addr_i >= addr_map_i[gi].start_addr) &&
                       (addr_i <  addr_map_i[gi].end_addr);
  end

  // Walk from the last rule down so the lowest-numbered match is the one kept.
  always_comb begin
    idx_o       = '0;
    dec_valid_o = 1'b0;
    for (int i = int'(NoRules) - 1; i >= 0; i--) begin
      if (match[i]) begin
        if (addr_map_i[i].idx < NoIndices) begin
          idx_o       = IdxWidth'(addr_map_i[i].idx);
          dec_valid_o = 1'b1;
        end else begin
          idx_o       = '0;
          dec_valid_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/apb_req_bridge.sv
// Valid/ready request port to a single APB master port feeding a demux:
// decodes the address to a port select, runs SETUP/ACCESS and returns a response.
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int unsigned NoMstPorts    = 32'd2,
  parameter int unsigned NoRules       = 32'd2,
  parameter int unsigned TimeoutCycles = 32'd255,
  parameter type         req_t         = apb_req_t,
  parameter type         resp_t        = apb_resp_t,
  parameter type         rule_t        = apb_rule_t,
  localparam int unsigned SelectWidth  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  addr_t                  req_addr_i,
  input  logic                   req_write_i,
  input  data_t                  req_wdata_i,
  input  strb_t                  req_strb_i,
  input  prot_t                  req_prot_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output data_t                  rsp_rdata_o,
  output logic                   rsp_err_o,
  input  rule_t                  addr_map_i [NoRules],
  output req_t                   apb_req_o,
  input  resp_t                  apb_resp_i,
  output logic [SelectWidth-1:0] select_o
);

  typedef logic [SelectWidth-1:0] select_t;

  state_e      state_q, state_d;
  req_t        apb_q, apb_d;
  select_t     sel_q, sel_d;
  data_t       rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] cnt_q, cnt_d;

  select_t dec_idx;
  logic    dec_valid;

  apb_req_bridge_addr_decode #(
    .NoIndices (NoMstPorts),
    .NoRules   (NoRules),
    .addr_t    (addr_t),
    .rule_t    (rule_t)
  ) i_addr_decode (
    .addr_i      (req_addr_i),
    .addr_map_i  (addr_map_i),
    .idx_o       (dec_idx),
    .dec_valid_o (dec_valid)
  );

  always_comb begin
    state_d     = state_q;
    apb_d       = apb_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (dec_valid) begin
            apb_d.paddr   = req_addr_i;
            apb_d.pwrite  = req_write_i;
            apb_d.pwdata  = req_wdata_i;
            apb_d.pstrb   = req_strb_i;
            apb_d.pprot   = req_prot_i;
            apb_d.psel    = 1'b1;
            apb_d.penable = 1'b0;
            sel_d         = dec_idx;
            state_d       = ST_SETUP;
          end else begin
            // Decode miss answers straight away without touching the APB side.
            rdata_d     = '0;
            err_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        apb_d.penable = 1'b1;
        cnt_d         = '0;
        state_d       = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_resp_i.pready) begin
          rdata_d       = apb_q.pwrite ? '0 : apb_resp_i.prdata;
          err_d         = apb_resp_i.pslverr;
          rsp_valid_d   = 1'b1;
          apb_d.psel    = 1'b0;
          apb_d.penable = 1'b0;
          state_d       = ST_RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == TimeoutCycles - 32'd1)) begin
          rdata_d       = '0;
          err_d         = 1'b1;
          rsp_valid_d   = 1'b1;
          apb_d.psel    = 1'b0;
          apb_d.penable = 1'b0;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      apb_q       <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      apb_q       <= apb_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign apb_req_o   = apb_q;
  assign select_o    = sel_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed vector table, random
// transactions against a behavioural model, and an asynchronous reset case.
module tb_apb_req_bridge;
  import apb_req_bridge_pkg::*;

  localparam int unsigned NMst = 2;
  localparam int unsigned NRul = 4;
  localparam int unsigned TO   = 8;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  addr_t     req_addr;
  data_t     req_wdata, rsp_rdata;
  strb_t     req_strb;
  prot_t     req_prot;
  apb_rule_t addr_map [NRul];
  apb_req_t  apb_req;
  apb_resp_t apb_resp;
  logic [0:0] sel;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  apb_req_bridge #(
    .NoMstPorts    (NMst),
    .NoRules       (NRul),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .req_prot_i  (req_prot),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .addr_map_i  (addr_map),
    .apb_req_o   (apb_req),
    .apb_resp_i  (apb_resp),
    .select_o    (sel)
  );

  typedef struct {
    addr_t addr;   logic wr;     data_t wdata;  strb_t strb;  prot_t prot;
    int    waits;  data_t prdata; logic slverr;  int    stall;
    logic  exp_hit; int exp_sel; data_t exp_rdata; logic exp_err; int exp_lat; int exp_acc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Spec-level address map lookup: first rule containing the address decides.
  function automatic void ref_decode(input addr_t a, output bit hit, output int s);
    hit = 1'b0;
    s   = 0;
    for (int i = 0; i < int'(NRul); i++) begin
      if (a >= addr_map[i].start_addr && a < addr_map[i].end_addr) begin
        hit = (addr_map[i].idx < NMst);
        s   = hit ? int'(addr_map[i].idx) : 0;
        return;
      end
    end
  endfunction

  function automatic vec_t model(input vec_t s);
    vec_t v;
    bit   hit;
    int   sidx;
    v = s;
    ref_decode(s.addr, hit, sidx);
    v.exp_hit = hit;
    v.exp_sel = sidx;
    if (!hit) begin
      v.exp_rdata = '0; v.exp_err = 1'b1; v.exp_lat = 1; v.exp_acc = 0;
    end else if (s.waits >= 0 && s.waits < int'(TO)) begin
      v.exp_acc   = s.waits + 1;
      v.exp_lat   = 3 + s.waits;
      v.exp_err   = s.slverr;
      v.exp_rdata = s.wr ? '0 : s.prdata;
    end else begin
      v.exp_acc = int'(TO); v.exp_lat = 2 + int'(TO); v.exp_err = 1'b1; v.exp_rdata = '0;
    end
    return v;
  endfunction

  // Drives one request from a negedge, acts as the APB slave, then completes
  // the response handshake while a second request is held pending.
  task automatic run_txn(input vec_t v, input string tag);
    int    lat, acc, setup, bad, osel;
    bit    done;
    data_t o_rdata;
    logic  o_err;
    lat = -1; acc = 0; setup = 0; bad = 0; osel = -1; done = 1'b0;
    o_rdata = '0; o_err = 1'b0;
    check({tag, " req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_addr = v.addr; req_write = v.wr;
    req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom);
    req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      apb_resp.pready = 1'b0; apb_resp.prdata = $urandom; apb_resp.pslverr = 1'($urandom);
      if (rsp_valid) begin
        lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err; done = 1'b1;
      end else begin
        if (apb_req.psel) begin
          if (apb_req.paddr !== v.addr || apb_req.pwrite !== v.wr || apb_req.pwdata !== v.wdata ||
              apb_req.pstrb !== v.strb || apb_req.pprot !== v.prot) bad++;
          osel = int'(sel);
          if (!apb_req.penable) begin
            setup++;
            apb_resp.pready = 1'b1;
          end else begin
            acc++;
            if (acc == v.waits + 1) begin
              apb_resp.pready = 1'b1; apb_resp.prdata = v.prdata; apb_resp.pslverr = v.slverr;
            end
          end
        end else if (apb_req.penable) begin
          bad++;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    apb_resp.pready = 1'b0;
    check({tag, " rsp_seen"}, done, 1);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " rdata"}, o_rdata, v.exp_rdata);
    check({tag, " err"}, o_err, v.exp_err);
    check({tag, " access_cycles"}, acc, v.exp_acc);
    check({tag, " setup_cycles"}, setup, v.exp_hit ? 1 : 0);
    check({tag, " select"}, osel, v.exp_hit ? v.exp_sel : -1);
    for (int k = 0; k < v.stall; k++) begin
      req_valid = 1'b1; req_addr = 32'h0000_0040;
      @(posedge clk); @(negedge clk);
      if (!rsp_valid || rsp_rdata !== o_rdata || rsp_err !== o_err || req_ready || apb_req.psel) bad++;
    end
    check({tag, " payload_stable"}, bad, 0);
    req_valid = 1'b1; req_addr = 32'h0000_0040;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({tag, " rsp_drop"}, rsp_valid, 0);
    check({tag, " idle_after_rsp"}, req_ready, 1);
    check({tag, " no_same_cycle_accept"}, apb_req.psel, 0);
    $display("txn %s addr=%h wr=%0d lat=%0d rdata=%h err=%0d sel=%0d", tag, v.addr, v.wr, lat, o_rdata, o_err, osel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t r;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_strb = '0; req_prot = '0;
    rsp_ready = 1'b0; apb_resp = '0;
    addr_map[0] = '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0000_1000};
    addr_map[1] = '{idx: 32'd1, start_addr: 32'h0000_1000, end_addr: 32'h0000_2000};
    addr_map[2] = '{idx: 32'd2, start_addr: 32'h0000_3000, end_addr: 32'h0000_4000};
    addr_map[3] = '{idx: 32'd0, start_addr: 32'h0000_1800, end_addr: 32'h0000_2800};

    //          addr          wr    wdata         strb  prot  waits prdata        slv   stall hit   sel rdata         err   lat acc
    vecs[0]  = '{32'h0000_1004, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'hDEADBEEF, 1'b0, 0,  1'b1, 1, 32'hDEADBEEF, 1'b0, 3,  1};
    vecs[1]  = '{32'h0000_0010, 1'b1, 32'hA5A5A5A5, 4'hF, 3'h2, 4,  32'h11111111, 1'b0, 0,  1'b1, 0, 32'h0,        1'b0, 7,  5};
    vecs[2]  = '{32'hFFFF_0000, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'h22222222, 1'b0, 0,  1'b0, 0, 32'h0,        1'b1, 1,  0};
    vecs[3]  = '{32'h0000_0100, 1'b0, 32'h0,        4'h0, 3'h1, -1, 32'h33333333, 1'b0, 0,  1'b1, 0, 32'h0,        1'b1, 10, 8};
    vecs[4]  = '{32'h0000_3004, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'h44444444, 1'b0, 0,  1'b0, 0, 32'h0,        1'b1, 1,  0};
    vecs[5]  = '{32'h0000_2000, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'h12345678, 1'b1, 0,  1'b1, 0, 32'h12345678, 1'b1, 3,  1};
    vecs[6]  = '{32'h0000_1800, 1'b1, 32'h0BADF00D, 4'h3, 3'h4, 1,  32'h55555555, 1'b0, 0,  1'b1, 1, 32'h0,        1'b0, 4,  2};
    vecs[7]  = '{32'h0000_0FFF, 1'b0, 32'h0,        4'h0, 3'h7, 0,  32'hCAFEF00D, 1'b0, 0,  1'b1, 0, 32'hCAFEF00D, 1'b0, 3,  1};
    vecs[8]  = '{32'h0000_2800, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'h66666666, 1'b0, 0,  1'b0, 0, 32'h0,        1'b1, 1,  0};
    vecs[9]  = '{32'h0000_0004, 1'b0, 32'h0,        4'h0, 3'h0, 0,  32'h5A5A0001, 1'b0, 10, 1'b1, 0, 32'h5A5A0001, 1'b0, 3,  1};
    vecs[10] = '{32'h0000_1000, 1'b0, 32'h0,        4'h0, 3'h0, 7,  32'h77777777, 1'b0, 0,  1'b1, 1, 32'h77777777, 1'b0, 10, 8};
    vecs[11] = '{32'h0000_1FFC, 1'b1, 32'h89ABCDEF, 4'hC, 3'h0, 8,  32'h88888888, 1'b0, 0,  1'b1, 1, 32'h0,        1'b1, 10, 8};

    repeat (2) @(negedge clk);
    check("reset req_ready", req_ready, 1);
    check("reset apb_req", apb_req, '0);
    check("reset select", sel, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      addr_t bases [8];
      bases = '{32'h0, 32'h1000, 32'h1800, 32'h2000, 32'h2800, 32'h3000, 32'h4000, 32'hFFFF_0000};
      r = '{default: 0};
      r.addr   = bases[$urandom_range(0, 7)] + addr_t'($urandom_range(0, 32'h7FF));
      r.wr     = 1'($urandom); r.wdata = $urandom; r.strb = 4'($urandom); r.prot = 3'($urandom);
      r.waits  = $urandom_range(0, 9); r.prdata = $urandom; r.slverr = 1'($urandom);
      r.stall  = $urandom_range(0, 3);
      run_txn(model(r), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while the transfer sits in ACCESS.
    req_valid = 1'b1; req_addr = 32'h0000_0100; req_write = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; apb_resp.pready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_reset psel", apb_req.psel, 1);
    check("pre_reset penable", apb_req.penable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset psel", apb_req.psel, 0);
    check("async_reset penable", apb_req.penable, 0);
    check("async_reset rsp_valid", rsp_valid, 0);
    check("async_reset idle", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset rsp_valid", rsp_valid, 0);
    check("post_reset psel", apb_req.psel, 0);
    $display("txn reset_in_access addr=%h", 32'h0000_0100);
    run_txn(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

Interface
REQ-001 SHALL have parameter NoMstPorts, default 32'd2, the number of downstream APB demux ports.
REQ-002 SHALL have parameter NoRules, default 32'd2, the number of address-map rules.
REQ-003 SHALL have parameter TimeoutCycles, default 32'd255, the maximum ACCESS-phase cycles; 0 disables the timeout.
REQ-004 SHALL have parameters req_t and resp_t, the APB request and response structs, and rule_t, a struct {idx, start_addr, end_addr}.
REQ-005 SHALL have derived parameter SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1, plus select_t; these are not for override.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 req_valid_i / req_ready_o  in/out  1  request handshake.
REQ-009 req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i  input  paddr/1/pwdata/pstrb/pprot widths  request payload.
REQ-010 rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
REQ-011 rsp_rdata_o, rsp_err_o  output  pwdata width/1  response payload.
REQ-012 addr_map_i  input  rule_t[NoRules]  address map; first matching rule wins; a rule matches when start_addr <= addr < end_addr.
REQ-013 apb_req_o / apb_resp_i  out/in  req_t/resp_t  APB master port, which feeds the demux slave port.
REQ-014 select_o  output  select_t  demux port index.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, ACCESS and RESP.
REQ-016 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-017 Handshake in IDLE with a decode hit SHALL latch the payload and select, then go to SETUP.
REQ-018 Handshake in IDLE with a decode miss SHALL go to RESP with rdata=0 and err=1, and no APB transfer SHALL occur.
REQ-019 SETUP (one cycle) SHALL drive psel=1 and penable=0, then go to ACCESS.
REQ-020 ACCESS SHALL drive psel=1 and penable=1 until pready=1, then capture prdata (reads; writes capture 0) and pslverr, and go to RESP.
REQ-021 In ACCESS, the cycle counter SHALL start at 0 on entry; when the counter reaches TimeoutCycles-1 with pready=0, the FSM SHALL go to RESP with err=1 and rdata=0, and psel SHALL drop next cycle.
REQ-022 RESP SHALL assert rsp_valid_o with stable payload until rsp_ready_i=1, then go to IDLE.
REQ-023 The next request SHALL NOT be accepted in that same cycle.
REQ-024 paddr, pwrite, pwdata, pstrb, pprot and select_o SHALL be driven from registers and held constant from SETUP through ACCESS.
REQ-025 Outside SETUP and ACCESS, psel=0 and penable=0.
REQ-026 Minimum request-to-rsp_valid_o latency SHALL be 3 cycles: accept, SETUP, ACCESS with pready=1, then RESP.
REQ-027 pready in SETUP SHALL be ignored.
REQ-028 addr_map_i SHALL be sampled only at acceptance.
REQ-029 A matched idx >= NoMstPorts SHALL be treated as a decode miss.

Reset
REQ-030 On rst_ni=0 (asynchronous), state SHALL be IDLE.
REQ-031 On reset, all APB request fields, select_o, rsp_rdata_o and the counter SHALL be 0, and rsp_valid_o and rsp_err_o SHALL be 0.
REQ-032 Reset mid-transfer SHALL drop psel and penable immediately, and the in-flight response SHALL be discarded.

Structure
REQ-033 Package apb_req_bridge_pkg SHALL hold the state enum and the rule_t template typedef macro usage.
REQ-034 Address decoding SHALL use one sub-module, addr_decode from common_cells, with NoIndices=NoMstPorts.

Verification
REQ-035 Read: addr 0x1004 (rule idx 1: 0x1000-0x2000), pready=1 at the first ACCESS cycle, prdata 0xDEADBEEF -> select_o=1, rsp_valid_o 3 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-036 Write with 4 wait states: pwdata 0xA5A5A5A5, pstrb 0xF -> penable high 5 cycles, payload stable throughout, err 0.
REQ-037 Unmapped addr 0xFFFF0000 -> psel never asserted, rsp_valid_o next cycle, err 1, rdata 0.
REQ-038 TimeoutCycles=8, pready held 0 -> 8 ACCESS cycles, then err 1 and psel 0.
REQ-039 rsp_ready_i held 0 for 10 cycles with req_valid_i=1 -> response stable, req_ready_o=0, second request accepted only after the RESP handshake.
REQ-040 Reset asserted during ACCESS -> psel, penable and rsp_valid_o go to 0 asynchronously, and the FSM is in IDLE after release.
